// File: rtl/ahb_apb_bridge_ctrl_if.sv
// Bus bundle between the AHB slave port, the APB master port and the
// posted-write status of the bridge controller.
interface ahb_apb_bridge_ctrl_if #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int NUM_SLAVES = 3,
  parameter int WBUF_DEPTH = 2
);
  localparam int CW = $clog2(WBUF_DEPTH + 1);

  logic                  Hsel, Hwrite, Hready_in;
  logic [1:0]            Htrans;
  logic [AW-1:0]         Haddr;
  logic [DW-1:0]         Hwdata;
  logic                  Hreadyout, Hresp;
  logic [DW-1:0]         Hrdata;
  logic [AW-1:0]         Paddr;
  logic [DW-1:0]         Pwdata;
  logic                  Pwrite, Penable;
  logic [NUM_SLAVES-1:0] Pselx;
  logic [DW-1:0]         Prdata;
  logic                  Pready, Pslverr;
  logic                  Werr_clr, Werr_sticky;
  logic [CW-1:0]         Wbuf_count;

  modport slave (
    input  Hsel, Hwrite, Hready_in, Htrans, Haddr, Hwdata, Prdata, Pready, Pslverr, Werr_clr,
    output Hreadyout, Hresp, Hrdata, Paddr, Pwdata, Pwrite, Penable, Pselx, Werr_sticky, Wbuf_count
  );
  modport master (
    output Hsel, Hwrite, Hready_in, Htrans, Haddr, Hwdata, Prdata, Pready, Pslverr, Werr_clr,
    input  Hreadyout, Hresp, Hrdata, Paddr, Pwdata, Pwrite, Penable, Pselx, Werr_sticky, Wbuf_count
  );
endinterface

// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-to-APB bridge control core: address decode, posted-write FIFO,
// strictly ordered reads and a three-state APB sequencer.
module ahb_apb_bridge_ctrl #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int NUM_SLAVES = 3,
  parameter int SLV_LSB    = 12,
  parameter int WBUF_DEPTH = 2
) (
  input logic Hclk,
  input logic Hreset,
  ahb_apb_bridge_ctrl_if.slave bus
);
  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW = $clog2(WBUF_DEPTH + 1);

  typedef enum logic [2:0] {D_IDLE, D_WR, D_RD, D_ERR1, D_ERR2} dp_st_t;
  typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} ap_st_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } wb_ent_t;

  dp_st_t        dp_st, dp_nxt;
  ap_st_t        ap_st, ap_nxt;
  logic [AW-1:0] dp_addr;
  logic [IW-1:0] dp_idx, h_idx, p_idx;
  logic          rd_pend, rd_set, cur_rd;
  logic          hready_q, hready_d, hresp_q, hresp_d;
  logic [DW-1:0] hrdata_q, hrdata_d;
  logic [AW-1:0] paddr_q;
  logic [DW-1:0] pwdata_q;
  logic          pwrite_q, werr_q;
  wb_ent_t       wbuf [WBUF_DEPTH];
  logic [PW-1:0] wptr, rptr, rptr_after;
  logic [CW-1:0] count, cnt_after, cnt_nxt;
  logic          accept, legal, push, retire, retire_wr, rd_done, load_wr, load_rd, load;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign h_idx      = bus.Haddr[SLV_LSB +: IW];
  assign legal      = ({1'b0, h_idx} < (IW+1)'(NUM_SLAVES));
  assign accept     = bus.Hsel & bus.Htrans[1] & bus.Hready_in;
  assign push       = (dp_st == D_WR) & hready_q;
  assign retire     = (ap_st == A_ACCESS) & bus.Pready;
  assign retire_wr  = retire & ~cur_rd;
  assign rd_done    = retire & cur_rd;
  assign cnt_after  = count - CW'(retire_wr);
  assign cnt_nxt    = cnt_after + CW'(push);
  assign rptr_after = retire_wr ? ptr_inc(rptr) : rptr;
  // A read only goes out once every older posted write has retired
  assign load_wr    = (cnt_after != '0);
  assign load_rd    = rd_pend & ~load_wr;

  // AHB data-phase sequencing
  always_comb begin
    dp_nxt   = dp_st;
    hready_d = hready_q;
    hresp_d  = hresp_q;
    hrdata_d = hrdata_q;
    rd_set   = 1'b0;
    case (dp_st)
      D_WR:   if (!hready_q) hready_d = (cnt_nxt < CW'(WBUF_DEPTH));
      D_RD:   if (rd_done) begin
                hrdata_d = bus.Pslverr ? '0 : bus.Prdata;
                hready_d = ~bus.Pslverr;
                hresp_d  = bus.Pslverr;
                dp_nxt   = bus.Pslverr ? D_ERR1 : D_IDLE;
              end
      D_ERR1: begin dp_nxt = D_ERR2; hready_d = 1'b1; hresp_d = 1'b1; end
      default: ;
    endcase
    if (hready_q) begin
      dp_nxt  = D_IDLE;
      hresp_d = 1'b0;
      if (accept) begin
        if (!legal) begin
          dp_nxt = D_ERR1; hready_d = 1'b0; hresp_d = 1'b1;
        end else if (bus.Hwrite) begin
          dp_nxt = D_WR; hready_d = (cnt_nxt < CW'(WBUF_DEPTH));
        end else begin
          dp_nxt = D_RD; hready_d = 1'b0; rd_set = 1'b1;
        end
      end else begin
        hready_d = 1'b1;
      end
    end
  end

  always_comb begin
    ap_nxt = ap_st;
    load   = 1'b0;
    case (ap_st)
      A_IDLE:   if (load_wr | load_rd) begin ap_nxt = A_SETUP; load = 1'b1; end
      A_SETUP:  ap_nxt = A_ACCESS;
      A_ACCESS: if (bus.Pready) begin
                  if (load_wr | load_rd) begin ap_nxt = A_SETUP; load = 1'b1; end
                  else ap_nxt = A_IDLE;
                end
      default:  ap_nxt = A_IDLE;
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      dp_st    <= D_IDLE;
      ap_st    <= A_IDLE;
      dp_addr  <= '0;
      dp_idx   <= '0;
      rd_pend  <= 1'b0;
      cur_rd   <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      hrdata_q <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      p_idx    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      werr_q   <= 1'b0;
    end else begin
      dp_st    <= dp_nxt;
      ap_st    <= ap_nxt;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      hrdata_q <= hrdata_d;
      if (accept) begin
        dp_addr <= bus.Haddr;
        dp_idx  <= h_idx;
      end
      if (rd_set) rd_pend <= 1'b1;
      else if (load && !load_wr) rd_pend <= 1'b0;
      if (load) begin
        if (load_wr) begin
          paddr_q  <= wbuf[rptr_after].addr;
          pwdata_q <= wbuf[rptr_after].data;
          p_idx    <= wbuf[rptr_after].idx;
          pwrite_q <= 1'b1;
          cur_rd   <= 1'b0;
        end else begin
          paddr_q  <= dp_addr;
          p_idx    <= dp_idx;
          pwrite_q <= 1'b0;
          cur_rd   <= 1'b1;
        end
      end
      if (push) wptr <= ptr_inc(wptr);
      rptr  <= rptr_after;
      count <= cnt_nxt;
      // A set wins over a clear landing in the same cycle
      if (retire_wr && bus.Pslverr) werr_q <= 1'b1;
      else if (bus.Werr_clr)        werr_q <= 1'b0;
    end
  end

  always_ff @(posedge Hclk) begin
    if (push) wbuf[wptr] <= '{addr: dp_addr, idx: dp_idx, data: bus.Hwdata};
  end

  assign bus.Hreadyout   = hready_q;
  assign bus.Hresp       = hresp_q;
  assign bus.Hrdata      = hrdata_q;
  assign bus.Paddr       = paddr_q;
  assign bus.Pwdata      = pwdata_q;
  assign bus.Pwrite      = pwrite_q;
  assign bus.Penable     = (ap_st == A_ACCESS);
  assign bus.Pselx       = (ap_st != A_IDLE) ? (NUM_SLAVES'(1) << p_idx) : '0;
  assign bus.Werr_sticky = werr_q;
  assign bus.Wbuf_count  = count;
endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Scoreboard bench for the AHB-to-APB bridge controller: directed AHB
// transfers, a scripted APB slave, and a negedge monitor that checks responses.
module tb_ahb_apb_bridge_ctrl;
  logic Hclk = 1'b0;
  logic Hreset;
  always #5 Hclk = ~Hclk;

  ahb_apb_bridge_ctrl_if #(.AW(32), .DW(32), .NUM_SLAVES(3), .WBUF_DEPTH(2)) bus();
  assign bus.Hready_in = bus.Hreadyout;

  ahb_apb_bridge_ctrl #(.AW(32), .DW(32), .NUM_SLAVES(3), .SLV_LSB(12), .WBUF_DEPTH(2)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .bus(bus));

  typedef struct { logic resp; logic chk_rd; logic [31:0] rdata; int lat; } ahb_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic write; logic [2:0] sel; } apb_exp_t;
  typedef struct { int sig; logic [63:0] exp; string name; } creq_t;

  ahb_exp_t exp_ahb[$];
  apb_exp_t exp_apb[$];
  creq_t    chk_q[$];

  int total = 0, bad = 0;
  int apb_waits = 0, clr_reqs = 0, clr_done = 0, wcnt = 0, dp_cyc = 0;
  bit apb_err = 0, clr_on_set = 0, dp_pend = 0, err1 = 0;
  logic [31:0] apb_rdata = '0;

  function automatic logic [63:0] sigval(int s);
    case (s)
      0: return 64'(bus.Hreadyout);
      1: return 64'(bus.Hresp);
      2: return 64'(bus.Hrdata);
      3: return 64'(bus.Pselx);
      4: return 64'(bus.Penable);
      5: return 64'(bus.Wbuf_count);
      6: return 64'(bus.Werr_sticky);
      7: return 64'(bus.Paddr);
      default: return 64'(exp_ahb.size() + exp_apb.size());
    endcase
  endfunction

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // APB slave model and scoreboard monitor share one process so the Pready
  // they agree on is the one the DUT samples at the next rising edge.
  always @(negedge Hclk) begin
    while (chk_q.size() != 0) begin
      creq_t r;
      r = chk_q.pop_front();
      cmp(r.name, sigval(r.sig), r.exp);
    end
    if (Hreset) begin
      dp_pend = 0; wcnt = 0;
      bus.Pready = 1'b0; bus.Pslverr = 1'b0; bus.Werr_clr = 1'b0; bus.Prdata = '0;
    end else begin
      bus.Prdata = apb_rdata;
      if (bus.Penable) begin
        if (wcnt < apb_waits) begin bus.Pready = 1'b0; wcnt++; end
        else begin bus.Pready = 1'b1; wcnt = 0; end
      end else bus.Pready = 1'b0;
      bus.Pslverr  = bus.Penable & bus.Pready & apb_err;
      bus.Werr_clr = 1'b0;
      if (clr_done < clr_reqs) begin bus.Werr_clr = 1'b1; clr_done++; end
      if (clr_on_set && bus.Pslverr && bus.Pwrite) bus.Werr_clr = 1'b1;

      if (dp_pend) begin
        dp_cyc++;
        if (!bus.Hreadyout && bus.Hresp) err1 = 1;
        if (bus.Hreadyout) begin
          if (exp_ahb.size() == 0) cmp("ahb_unexpected_resp", 64'(exp_ahb.size()), 1);
          else begin
            ahb_exp_t e;
            e = exp_ahb.pop_front();
            cmp("hresp", 64'(bus.Hresp), 64'(e.resp));
            if (e.resp) cmp("err_first_cycle", 64'(err1), 1);
            if (e.chk_rd) cmp("hrdata", 64'(bus.Hrdata), 64'(e.rdata));
            if (e.lat >= 0) cmp("ahb_latency", 64'(dp_cyc), 64'(e.lat));
          end
          dp_pend = 0;
        end
      end
      if (bus.Hsel && bus.Htrans[1] && bus.Hready_in) begin
        dp_pend = 1; dp_cyc = 0; err1 = 0;
      end

      if (bus.Pselx != '0) begin
        if (exp_apb.size() == 0) begin
          if (!bus.Penable) cmp("apb_unexpected", 64'(bus.Pselx), 0);
        end else begin
          apb_exp_t a;
          a = exp_apb[0];
          if (!bus.Penable) begin
            cmp("setup_pselx", 64'(bus.Pselx), 64'(a.sel));
            if (!a.write) cmp("rd_setup_wbuf_empty", 64'(bus.Wbuf_count), 0);
          end else if (bus.Pready) begin
            cmp("access_pselx", 64'(bus.Pselx), 64'(a.sel));
            cmp("paddr", 64'(bus.Paddr), 64'(a.addr));
            cmp("pwrite", 64'(bus.Pwrite), 64'(a.write));
            if (a.write) cmp("pwdata", 64'(bus.Pwdata), 64'(a.data));
            void'(exp_apb.pop_front());
          end
        end
      end
    end
  end

  task automatic req(int s, logic [63:0] e, string nm);
    creq_t r;
    r.sig = s; r.exp = e; r.name = nm;
    chk_q.push_back(r);
  endtask

  task automatic step();
    @(posedge Hclk); #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    bus.Hsel = 1'b1; bus.Htrans = 2'b10; bus.Hwrite = w; bus.Haddr = a;
    n = 0;
    do begin @(negedge Hclk); n++; end while (!bus.Hreadyout && n < 200);
    step();
    bus.Hwdata = d; bus.Hsel = 1'b0; bus.Htrans = 2'b00;
  endtask

  // sel == 0 marks an address that must not reach APB
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int lat, input logic [2:0] sel);
    ahb_exp_t e;
    apb_exp_t p;
    e.resp = (sel == 3'b000); e.chk_rd = 1'b0; e.rdata = '0; e.lat = lat;
    exp_ahb.push_back(e);
    if (sel != 3'b000) begin
      p.addr = a; p.data = d; p.write = 1'b1; p.sel = sel;
      exp_apb.push_back(p);
    end
    issue(1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] rdat, input logic resp,
                    input int lat, input logic [2:0] sel);
    ahb_exp_t e;
    apb_exp_t p;
    e.resp = resp; e.chk_rd = (sel != 3'b000); e.rdata = rdat; e.lat = lat;
    exp_ahb.push_back(e);
    if (sel != 3'b000) begin
      p.addr = a; p.data = '0; p.write = 1'b0; p.sel = sel;
      exp_apb.push_back(p);
    end
    issue(1'b0, a, 32'h0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_ahb.size() != 0 || exp_apb.size() != 0 || bus.Wbuf_count != 0 ||
            bus.Pselx != 0 || !bus.Hreadyout) && n < 300) begin
      step(); n++;
    end
    req(8, 0, "pending_txn");
    req(5, 0, "wbuf_drained");
    step();
    exp_ahb.delete(); exp_apb.delete();
  endtask

  initial begin
    int n;
    bus.Hsel = 1'b0; bus.Htrans = 2'b00; bus.Hwrite = 1'b0; bus.Haddr = '0; bus.Hwdata = '0;
    Hreset = 1'b1;
    repeat (3) @(posedge Hclk);
    #1 Hreset = 1'b0;
    step();
    req(0, 1, "rst_hreadyout"); req(1, 0, "rst_hresp");   req(2, 0, "rst_hrdata");
    req(3, 0, "rst_pselx");     req(4, 0, "rst_penable"); req(5, 0, "rst_wbuf_count");
    req(6, 0, "rst_werr");      req(7, 0, "rst_paddr");
    step();

    apb_waits = 3; apb_rdata = 32'hDEAD_BEEF;
    rd(32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 7, 3'b010);
    wait_idle();

    apb_waits = 0; apb_rdata = 32'h1234_5678;
    rd(32'h0000_0010, 32'h1234_5678, 1'b0, 4, 3'b001);
    wait_idle();

    wr(32'h0000_0040, 32'hA5A5_0001, 1, 3'b001);
    step(); req(5, 1, "wr_count_c2");
    step(); req(4, 0, "wr_setup_penable"); req(3, 3'b001, "wr_setup_pselx");
    step(); req(4, 1, "wr_access_penable"); req(5, 1, "wr_count_c4");
    step(); req(5, 0, "wr_count_c5");
    wait_idle();

    wr(32'h0000_0100, 32'hA000_0000, 1, 3'b001);
    wr(32'h0000_0104, 32'hA000_0001, 1, 3'b001);
    wr(32'h0000_0108, 32'hA000_0002, 3, 3'b001);
    wr(32'h0000_010C, 32'hA000_0003, -1, 3'b001);
    wait_idle();

    apb_rdata = 32'hCAFE_F00D;
    wr(32'h0000_2008, 32'h0000_0055, 1, 3'b100);
    rd(32'h0000_200C, 32'hCAFE_F00D, 1'b0, -1, 3'b100);
    wait_idle();

    rd(32'h0000_3000, 32'h0, 1'b1, 2, 3'b000);
    wait_idle();
    wr(32'h0000_3010, 32'h0000_0099, 2, 3'b000);
    wait_idle();

    apb_err = 1; apb_rdata = 32'hFFFF_FFFF;
    rd(32'h0000_0020, 32'h0, 1'b1, 5, 3'b001);
    wait_idle();

    wr(32'h0000_1010, 32'h0000_0077, 1, 3'b010);
    wait_idle();
    apb_err = 0;
    req(6, 1, "werr_set");
    clr_reqs++;
    step(); step();
    req(6, 0, "werr_cleared");
    step();

    clr_on_set = 1; apb_err = 1;
    wr(32'h0000_1014, 32'h0000_0088, 1, 3'b010);
    wait_idle();
    clr_on_set = 0; apb_err = 0;
    req(6, 1, "werr_set_beats_clr");
    clr_reqs++;
    step(); step();
    req(6, 0, "werr_cleared2");
    step();

    apb_waits = 50;
    wr(32'h0000_0200, 32'hB000_0000, 1, 3'b001);
    wr(32'h0000_0204, 32'hB000_0001, 1, 3'b001);
    n = 0;
    while (!bus.Penable && n < 50) begin step(); n++; end
    req(4, 1, "pre_rst_penable"); req(5, 2, "pre_rst_count");
    step();
    #1 Hreset = 1'b1;
    exp_apb.delete();
    req(3, 0, "async_rst_pselx"); req(4, 0, "async_rst_penable");
    req(5, 0, "async_rst_count"); req(0, 1, "async_rst_hreadyout");
    step(); step();
    Hreset = 1'b0; apb_waits = 0;
    repeat (20) step();
    req(3, 0, "no_stale_pselx");
    wait_idle();

    apb_rdata = 32'h0BAD_F00D;
    rd(32'h0000_2000, 32'h0BAD_F00D, 1'b0, 4, 3'b100);
    wait_idle();

    @(negedge Hclk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_apb_bridge_ctrl.md
# ahb_apb_bridge_ctrl

Parametrised AHB-to-APB bridge controller: the next-generation control core between the AHB slave interface and the APB peripheral bus. It has configurable address/data width and slave count, and decodes the slave select from the address. It supports APB wait states (Pready) and error responses (Pslverr), and posts writes through a WBUF_DEPTH-entry buffer so AHB write data phases complete with zero wait states while APB drains behind them.

## Interface
- AW, 32: address width (Haddr, Paddr).
- DW, 32: data width (Hwdata, Hrdata, Pwdata, Prdata).
- NUM_SLAVES, 3: number of APB slaves, 1..16; width of Pselx.
- SLV_LSB, 12: LSB of the slave-index field; the index is Haddr[SLV_LSB +: IW], where IW = max(1, clog2(NUM_SLAVES)).
- WBUF_DEPTH, 2: number of posted-write entries, 1..8.

Ports:
- Hclk  in  1  single clock, rising edge.
- Hreset  in  1  asynchronous, active-high reset.
- Hsel, Hwrite, Hready_in  in  1 each  AHB select, direction, and bus-ready.
- Htrans  in  2  AHB transfer type. NONSEQ=2'b10 and SEQ=2'b11 are transfers; IDLE and BUSY are not.
- Haddr  in  AW;  Hwdata  in  DW.
- Hreadyout  out  1  AHB ready. Registered; reset 1.
- Hresp  out  1  1=ERROR. Registered; reset 0.
- Hrdata  out  DW  read data. Registered; reset 0.
- Paddr  out  AW;  Pwdata  out  DW;  Pwrite  out  1. Reset 0.
- Pselx  out  NUM_SLAVES  one-hot select. Reset 0.
- Penable  out  1  reset 0.
- Prdata  in  DW;  Pready, Pslverr  in  1. These are muxed externally from the selected slave.
- Werr_clr  in  1  clears Werr_sticky.
- Werr_sticky  out  1  a posted write received Pslverr. Reset 0.
- Wbuf_count  out  clog2(WBUF_DEPTH+1)  buffer occupancy. Reset 0.

## Operation
- **Accept:** a transfer is accepted when Hsel & Htrans[1] & Hready_in in an address phase. Haddr and Hwrite are captured at that edge.
- **Decode:** if the slave index is ≥ NUM_SLAVES, the transfer is illegal.
  - No APB access is made and nothing is buffered.
  - Data phase is a two-cycle ERROR: (Hreadyout=0, Hresp=1), then (Hreadyout=1, Hresp=1).
- **Legal write, buffer not full:** Hreadyout=1 in the data phase. {addr, index, Hwdata} is pushed at the end of that data-phase cycle.
- **Legal write, buffer full:** Hreadyout=0 while full. The push happens in the first data-phase cycle where Hreadyout=1.
- **Legal read:** Hreadyout=0 until complete. The read is not issued until the buffer is empty (strict ordering), then it takes the APB path below.
- **APB FSM states:** IDLE, SETUP, ACCESS.
  - IDLE→SETUP when the buffer is non-empty (head entry), or a pending read exists and the buffer is empty.
  - SETUP: Pselx=one-hot(index), Penable=0, Paddr/Pwrite/Pwdata valid. Always →ACCESS.
  - ACCESS: Penable=1, with Pselx/Paddr/Pwrite/Pwdata held. Stays in ACCESS while Pready=0.
  - On Pready=1 the entry retires. Next state is SETUP if more work is pending, else IDLE.
  - In IDLE, Pselx=0 and Penable=0. Paddr, Pwdata and Pwrite hold their last values.
- **Read completion:**
  - Pready & ~Pslverr: Hrdata←Prdata, Hreadyout=1, Hresp=0 the next cycle.
  - Pready & Pslverr: Hrdata←0, then the two-cycle ERROR response.
- **Posted-write error:** Pready & Pslverr on a buffered write sets Werr_sticky. AHB sees no error.
- **Werr_clr:** clears Werr_sticky. A set and a clear in the same cycle leave it set.
- **No transfer:** Hsel=0, or Htrans IDLE/BUSY, gives an OKAY zero-wait response (Hreadyout stays 1).
- **Simultaneous push and retire:** in one cycle, Wbuf_count is unchanged. Entries drain in FIFO order, and pointers wrap modulo WBUF_DEPTH.
- **Reset mid-operation:** all outputs go to their reset values immediately. The buffer and any pending read are discarded, and the FSM goes to IDLE.

## Timing
- **Read, empty buffer, Pready=1:**
  - Cycle 0: address phase.
  - Cycle 1: data phase, Hreadyout=0; FSM in IDLE captures the read.
  - Cycle 2: SETUP.
  - Cycle 3: ACCESS.
  - Cycle 4: Hreadyout=1, Hrdata valid.
  - Each Pready=0 cycle adds one cycle.
- **Write, buffer empty:**
  - Cycle 1: data phase, Hreadyout=1.
  - Cycle 2: Wbuf_count=1.
  - Cycle 3: SETUP.
  - Cycle 4: ACCESS.
  - With Pready=1, Wbuf_count=0 in cycle 5.
- **Back-to-back accesses:** APB throughput is one access per 2 cycles, with no idle between them.
- **Full buffer:** Hreadyout rises in the cycle after the ACCESS cycle that retires an entry.

## Test plan
- **Read, slave 1, 3 wait states:** Haddr=32'h0000_1004, Prdata=32'hDEAD_BEEF, Pready low for 3 ACCESS cycles.
  - Pselx=3'b010 through SETUP and ACCESS.
  - Hreadyout=1 with Hrdata=32'hDEAD_BEEF at cycle 7.
- **Write burst, WBUF_DEPTH=2:** four back-to-back writes to slave 0 with Pready=1.
  - Writes 1-2 complete with zero wait.
  - Write 3 waits until the first retire.
  - APB order and data match AHB order.
- **Ordering:** write then read to slave 2. The APB write completes before the read's SETUP, and Wbuf_count=0 at that point.
- **Illegal slave:** Haddr=32'h0000_3000 with NUM_SLAVES=3.
  - Pselx stays 0.
  - Two-cycle ERROR: (0,1) then (1,1).
- **Pslverr:**
  - Read with Pslverr gives the ERROR response and Hrdata=0.
  - Posted write with Pslverr sets Werr_sticky. A Werr_clr pulse clears it.
  - Werr_clr in the same cycle as a set leaves it set.
- **Reset mid-ACCESS:** Hreset asserted with 2 entries buffered.
  - Pselx, Penable and Wbuf_count go to 0 asynchronously; Hreadyout goes to 1.
  - After release, no stale APB access occurs.
